// File: rtl/ro_puf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_pkg
// Description : Shared types and constants for the ring-oscillator PUF
//               sequencer (FSM state encoding, synchronizer depth, drain time).
// Revision    : 1.0 - initial release
// ============================================================================
package ro_puf_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SETTLE = 3'd2,
    COUNT  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Flops in each RO synchronizer chain before the edge detector
  localparam int SYNC_STAGES = 2;

  // Cycles spent after ro_en drops, letting in-flight edges leave the pipeline
  localparam int DRAIN_CYC = 3;

endpackage : ro_puf_pkg
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : ro_edge_counter
// Description : Synchronizes one raw ring-oscillator output, detects its
//               rising edges and counts them into a saturating counter while
//               counting is enabled. clr has priority over counting.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_raw,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_edge;

  // Bring the asynchronous RO output into clk domain and keep a delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_raw};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Count detected rising edges, holding at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (cnt_en && w_edge && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule : ro_edge_counter
`default_nettype wire

// File: rtl/ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_ctrl
// Description : Challenge sequencer for a bank of enable-gated ring
//               oscillators. Enables the selected pair, waits for them to
//               settle, counts their edges over a programmable window, turns
//               them off, drains the synchronizers and compares the counts
//               into one response bit.
//               Optional build macro RO_PUF_ABORT_EN adds an abort input that
//               cuts a running measurement short and reports err.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  chal_a,
  input  logic [SEL_W-1:0]  chal_b,
  input  logic [WIN_W-1:0]  win_len,
`ifdef RO_PUF_ABORT_EN
  input  logic              abort,
`endif
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              done,
  output logic              resp_bit,
  output logic              tie,
  output logic              err,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  // Timer reload values, sized to the shared down-counter
  localparam logic [WIN_W-1:0] C_SETTLE  = WIN_W'(SETTLE_CYC);
  localparam logic [WIN_W-1:0] C_DRAIN   = WIN_W'(DRAIN_CYC);
  localparam logic [WIN_W-1:0] C_ONE     = WIN_W'(1);
  localparam logic [SEL_W:0]   C_NUM_RO  = (SEL_W+1)'(NUM_RO);
  localparam int               C_PAD_W   = 1 << SEL_W;

  state_t             r_state;
  logic [WIN_W-1:0]   r_timer;
  logic [SEL_W-1:0]   r_chal_a;
  logic [SEL_W-1:0]   r_chal_b;
  logic [WIN_W-1:0]   r_win_len;
  logic [NUM_RO-1:0]  r_ro_en;
  logic               r_busy;
  logic               r_done;
  logic               r_resp_bit;
  logic               r_tie;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
`ifdef RO_PUF_ABORT_EN
  logic               r_aborted;
  logic               w_abort_hit;
`endif

  logic               w_accept;
  logic               w_chal_ok;
  logic [WIN_W-1:0]   w_win_eff;
  logic [NUM_RO-1:0]  w_en_mask;
  logic [C_PAD_W-1:0] w_ro_pad;
  logic               w_ro_a;
  logic               w_ro_b;
  logic               w_cnt_en;
  logic [CNT_W-1:0]   w_cnt_a;
  logic [CNT_W-1:0]   w_cnt_b;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_cnt_en  = (r_state == COUNT);
  assign w_win_eff = (r_win_len == '0) ? C_ONE : r_win_len;

  // A challenge is usable only with two distinct, in-range RO indices
  assign w_chal_ok = (r_chal_a != r_chal_b) &&
                     ({1'b0, r_chal_a} < C_NUM_RO) &&
                     ({1'b0, r_chal_b} < C_NUM_RO);

`ifdef RO_PUF_ABORT_EN
  assign w_abort_hit = abort && ((r_state == CHECK) || (r_state == SETTLE) ||
                                 (r_state == COUNT) || (r_state == DRAIN));
`endif

  // One-hot pair mask for the latched challenge
  always_comb begin
    w_en_mask = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      w_en_mask[i] = (SEL_W'(i) == r_chal_a) || (SEL_W'(i) == r_chal_b);
    end
  end

  // Zero-pad the RO bank to the full index range so any index selects safely
  always_comb begin
    w_ro_pad             = '0;
    w_ro_pad[NUM_RO-1:0] = ro_in;
  end

  assign w_ro_a = w_ro_pad[r_chal_a];
  assign w_ro_b = w_ro_pad[r_chal_b];

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_raw (w_ro_a),
    .clr    (w_accept),
    .cnt_en (w_cnt_en),
    .cnt    (w_cnt_a)
  );

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_raw (w_ro_b),
    .clr    (w_accept),
    .cnt_en (w_cnt_en),
    .cnt    (w_cnt_b)
  );

  // Measurement sequencer: state, shared down-timer and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_chal_a   <= '0;
      r_chal_b   <= '0;
      r_win_len  <= '0;
      r_ro_en    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_resp_bit <= 1'b0;
      r_tie      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
`ifdef RO_PUF_ABORT_EN
      r_aborted  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef RO_PUF_ABORT_EN
      // Abort drops the ROs at once and spends one drain cycle before DONE
      if (w_abort_hit) begin
        r_ro_en   <= '0;
        r_timer   <= C_ONE;
        r_aborted <= 1'b1;
        r_state   <= DRAIN;
      end else
`endif
      begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_chal_a   <= chal_a;
              r_chal_b   <= chal_b;
              r_win_len  <= win_len;
              r_busy     <= 1'b1;
              r_resp_bit <= 1'b0;
              r_tie      <= 1'b0;
              r_err      <= 1'b0;
              r_cnt_a    <= '0;
              r_cnt_b    <= '0;
`ifdef RO_PUF_ABORT_EN
              r_aborted  <= 1'b0;
`endif
              r_state    <= CHECK;
            end
          end
          CHECK: begin
            if (w_chal_ok) begin
              r_ro_en <= w_en_mask;
              r_timer <= C_SETTLE;
              r_state <= SETTLE;
            end else begin
              // Bad challenge: report straight away, ROs never switched on
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
          SETTLE: begin
            if (r_timer == C_ONE) begin
              r_timer <= w_win_eff;
              r_state <= COUNT;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          COUNT: begin
            if (r_timer == C_ONE) begin
              r_ro_en <= '0;
              r_timer <= C_DRAIN;
              r_state <= DRAIN;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          DRAIN: begin
            if (r_timer == C_ONE) begin
`ifdef RO_PUF_ABORT_EN
              if (r_aborted) begin
                r_err      <= 1'b1;
                r_resp_bit <= 1'b0;
                r_tie      <= 1'b0;
                r_cnt_a    <= '0;
                r_cnt_b    <= '0;
              end else
`endif
              begin
                r_cnt_a    <= w_cnt_a;
                r_cnt_b    <= w_cnt_b;
                r_resp_bit <= (w_cnt_a > w_cnt_b);
                r_tie      <= (w_cnt_a == w_cnt_b);
                r_err      <= 1'b0;
              end
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_ro_en <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign ro_en    = r_ro_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign resp_bit = r_resp_bit;
  assign tie      = r_tie;
  assign err      = r_err;
  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;

endmodule : ro_puf_ctrl
`default_nettype wire

// File: tb/tb_ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_puf_ctrl
// Description : Self-checking bench for ro_puf_ctrl: directed challenges with
//               modelled ring oscillators, a scoreboard of expected results,
//               a narrow-counter instance for saturation, and reset/restart
//               scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  chal_a;
  logic [2:0]  chal_b;
  logic [15:0] win_len;
  logic [7:0]  ro_in;
  logic [7:0]  ro_en;
  logic        busy;
  logic        done;
  logic        resp_bit;
  logic        tie;
  logic        err;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`ifdef RO_PUF_ABORT_EN
  logic        abort;
`endif

  logic        start4;
  logic [2:0]  chal_a4;
  logic [2:0]  chal_b4;
  logic [15:0] win_len4;
  logic [7:0]  ro_en4;
  logic        busy4;
  logic        done4;
  logic        resp4;
  logic        tie4;
  logic        err4;
  logic [3:0]  cnt_a4;
  logic [3:0]  cnt_b4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int ro_cyc  = 0;
  // Half-period of each modelled RO in clk cycles; 0 means stuck low
  int half[8] = '{2, 4, 0, 4, 0, 5, 4, 0};

  typedef struct {
    logic err;
    logic resp;
    logic tie;
    int   a_lo;
    int   a_hi;
    int   b_lo;
    int   b_hi;
    int   lat;
  } exp_t;

  exp_t sb[$];

  ro_puf_ctrl #(
    .NUM_RO(8), .SEL_W(3), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .win_len(win_len),
`ifdef RO_PUF_ABORT_EN
    .abort(abort),
`endif
    .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .done(done),
    .resp_bit(resp_bit), .tie(tie), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  ro_puf_ctrl #(
    .NUM_RO(8), .SEL_W(3), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(16)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .chal_a(chal_a4), .chal_b(chal_b4),
    .win_len(win_len4),
`ifdef RO_PUF_ABORT_EN
    .abort(1'b0),
`endif
    .ro_in(ro_in), .ro_en(ro_en4), .busy(busy4), .done(done4),
    .resp_bit(resp4), .tie(tie4), .err(err4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ring-oscillator models, all phase-aligned to a common cycle count
  always @(negedge clk) begin
    ro_cyc <= ro_cyc + 1;
    for (int i = 0; i < 8; i++) begin
      ro_in[i] <= (half[i] == 0) ? 1'b0 : 1'(((ro_cyc / half[i]) % 2));
    end
  end

  // Count done pulses of the main instance
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Launch one challenge, scramble inputs mid-run, optionally re-pulse start,
  // then pop the expectation when done appears and compare.
  task automatic run(input string tag, input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] w, input exp_t e, input int restart_at);
    int         n;
    logic       seen;
    logic [7:0] em;
    exp_t       x;
    sb.push_back(e);
    em = '0;
    if (!e.err) begin
      em[a] = 1'b1;
      em[b] = 1'b1;
    end
    chal_a  = a;
    chal_b  = b;
    win_len = w;
    start   = 1'b1;
    n       = 0;
    seen    = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      if (n == (e.lat >> 1)) chk({tag, "_ro_en"}, 32'(ro_en), 32'(em));
      start = (n == restart_at);
      if (n == 1) begin
        chal_a  = 3'd0;
        chal_b  = 3'd0;
        win_len = 16'd5;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      x = sb.pop_front();
      chk({tag, "_latency"}, 32'(n), 32'(x.lat));
      chk({tag, "_err"}, 32'(err), 32'(x.err));
      chk({tag, "_resp"}, 32'(resp_bit), 32'(x.resp));
      chk({tag, "_tie"}, 32'(tie), 32'(x.tie));
      chk_rng({tag, "_cnt_a"}, int'(cnt_a), x.a_lo, x.a_hi);
      chk_rng({tag, "_cnt_b"}, int'(cnt_b), x.b_lo, x.b_hi);
      chk({tag, "_ro_en_off"}, 32'(ro_en), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int   n;
    int   d0;
    exp_t e;
    logic seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    chal_a   = '0;
    chal_b   = '0;
    win_len  = '0;
    start4   = 1'b0;
    chal_a4  = '0;
    chal_b4  = '0;
    win_len4 = '0;
`ifdef RO_PUF_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp_bit), 32'd0);
    chk("rst_tie", 32'(tie), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // RO3 period 8, RO5 period 10 over 400 cycles
    e = '{err: 1'b0, resp: 1'b1, tie: 1'b0, a_lo: 49, a_hi: 51, b_lo: 39, b_hi: 41, lat: 421};
    run("t1", 3'd3, 3'd5, 16'd400, e, 0);

    // Identical indices are rejected without enabling anything
    e = '{err: 1'b1, resp: 1'b0, tie: 1'b0, a_lo: 0, a_hi: 0, b_lo: 0, b_hi: 0, lat: 2};
    run("t2", 3'd2, 3'd2, 16'd400, e, 0);

    // Two identical, in-phase ROs must tie
    e = '{err: 1'b0, resp: 1'b0, tie: 1'b1, a_lo: 12, a_hi: 13, b_lo: 12, b_hi: 13, lat: 121};
    run("t3", 3'd1, 3'd6, 16'd100, e, 0);
    chk("t3_equal", 32'(cnt_a), 32'(cnt_b));

    // Zero window behaves as a single cycle; stuck ROs give zero counts
    e = '{err: 1'b0, resp: 1'b0, tie: 1'b1, a_lo: 0, a_hi: 0, b_lo: 0, b_hi: 0, lat: 22};
    run("tw0", 3'd7, 3'd4, 16'd0, e, 0);

    // Narrow counter saturates at 15: RO0 gives 50 edges in 200 cycles
    chal_a4  = 3'd0;
    chal_b4  = 3'd7;
    win_len4 = 16'd200;
    start4   = 1'b1;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      start4 = 1'b0;
      if (done4) seen = 1'b1;
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_latency", 32'(n), 32'd221);
    chk("t4_cnt_a_sat", 32'(cnt_a4), 32'd15);
    chk("t4_cnt_b", 32'(cnt_b4), 32'd0);
    chk("t4_resp", 32'(resp4), 32'd1);
    chk("t4_err", 32'(err4), 32'd0);

    // Reset in the middle of COUNT drops everything asynchronously
    chal_a  = 3'd3;
    chal_b  = 3'd5;
    win_len = 16'd400;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("t5_ro_en_on", 32'(ro_en), 32'h28);
    chk("t5_busy_on", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ro_en_async", 32'(ro_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = '{err: 1'b0, resp: 1'b1, tie: 1'b0, a_lo: 49, a_hi: 51, b_lo: 39, b_hi: 41, lat: 421};
    run("t5_rerun", 3'd3, 3'd5, 16'd400, e, 0);

    // A second start during COUNT must not spawn another measurement
    d0 = n_done;
    run("t6", 3'd3, 3'd5, 16'd400, e, 300);
    repeat (30) @(negedge clk);
    chk("t6_one_done", 32'(n_done - d0), 32'd1);
    chk("t6_idle_busy", 32'(busy), 32'd0);

`ifdef RO_PUF_ABORT_EN
    // Abort in COUNT: ro_en off next cycle, done the cycle after
    chal_a  = 3'd3;
    chal_b  = 3'd5;
    win_len = 16'd400;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_ro_en", 32'(ro_en), 32'd0);
    chk("ab_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_err", 32'(err), 32'd1);
    chk("ab_cnt_a", 32'(cnt_a), 32'd0);
    chk("ab_cnt_b", 32'(cnt_b), 32'd0);
    chk("ab_resp", 32'(resp_bit), 32'd0);
    repeat (3) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ro_puf_ctrl
`default_nettype wire
